// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1) with a small byte FIFO.
// Oversamples the synchronized line, frames bytes LSB first and buffers good
// bytes for a valid/ready consumer. Flags framing errors and overruns.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned AW    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = AW + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  // Receiver state
  logic             rx_meta_q, rx_s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_req_q, push_req_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;

  // FIFO state
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             valid_q, valid_d;
  logic [7:0]       head_q, head_d;
  logic             overrun_q, overrun_d;

  logic pop_c, full_c, push_ok_c;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      push_req_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      push_req_q  <= push_req_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  // Receiver next-state: mid-bit sampling driven by the bit-period counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_req_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push_req_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // FIFO control: a push into a full FIFO survives only if a pop frees a slot.
  always_comb begin
    pop_c     = valid_q && rx_ready_i;
    full_c    = (occ_q == OCC_FULL);
    push_ok_c = push_req_q && (!full_c || pop_c);
    overrun_d = push_req_q && full_c && !pop_c;

    wr_ptr_d = wr_ptr_q + AW'(push_ok_c);
    rd_ptr_d = rd_ptr_q + AW'(pop_c);

    occ_d = occ_q;
    if (push_ok_c && !pop_c) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!push_ok_c && pop_c) begin
      occ_d = occ_q - OCC_W'(1);
    end

    valid_d = (occ_d != '0);

    // The byte being written becomes the head when it lands in the read slot.
    if (push_ok_c && (wr_ptr_q == rd_ptr_d)) begin
      head_d = shift_q;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO storage, pointers and registered head/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      valid_q   <= 1'b0;
      head_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push_ok_c) begin
        mem_q[wr_ptr_q] <= shift_q;
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      valid_q   <= valid_d;
      head_q    <= head_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_data_o   = head_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a table of single frames plus hand-written
// sequences for latency, glitch, break, overrun, mid-frame reset, back-to-back.
module tb_uart_rx_fifo;

  localparam int unsigned CPB   = 100;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_i;
  logic       rx_ready_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int tests = 0;
  int fails = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] popped [$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx_i),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  // Pulse counters and pop capture, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_err_o) ferr_cnt++;
    if (overrun_o) ovr_cnt++;
    if (rst_n && rx_valid_o && rx_ready_i) popped.push_back(rx_data_o);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    cyc(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    rx_i = 1'b1;
  endtask

  task automatic pop_all(input int n);
    rx_ready_i = 1'b1;
    cyc(n);
    rx_ready_i = 1'b0;
    cyc(1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int base_f, base_o, n, busy_n;
    logic in_win;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hA5, exp_ferr: 0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h00, exp_ferr: 0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hFF, exp_ferr: 0};
    vecs[3] = '{data: 8'h3C, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1};
    vecs[4] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h81, exp_ferr: 0};

    rst_n = 1'b0;
    rx_i = 1'b1;
    rx_ready_i = 1'b0;
    cyc(3);
    check("reset_valid", rx_valid_o, 0);
    check("reset_data", rx_data_o, 8'h00);
    check("reset_ferr", frame_err_o, 0);
    check("reset_ovr", overrun_o, 0);
    check("reset_busy", busy_o, 0);
    rst_n = 1'b1;
    cyc(5);
    check("idle_busy", busy_o, 0);

    // Table of single frames, consumer stalled until the checks are done.
    for (int v = 0; v < 5; v++) begin
      base_f = ferr_cnt;
      base_o = ovr_cnt;
      popped.delete();
      send_frame(vecs[v].data, vecs[v].stop);
      cyc(CPB);
      check($sformatf("vec%0d_valid", v), rx_valid_o, vecs[v].exp_valid);
      if (vecs[v].exp_valid) check($sformatf("vec%0d_data", v), rx_data_o, vecs[v].exp_data);
      check($sformatf("vec%0d_ferr", v), ferr_cnt - base_f, vecs[v].exp_ferr);
      check($sformatf("vec%0d_ovr", v), ovr_cnt - base_o, 0);
      check($sformatf("vec%0d_busy", v), busy_o, 0);
      pop_all(1);
      check($sformatf("vec%0d_popcnt", v), popped.size(), vecs[v].exp_valid ? 1 : 0);
      check($sformatf("vec%0d_empty", v), rx_valid_o, 0);
    end

    // Start-edge to valid latency: about 9.5 bit times plus a few cycles.
    base_f = ferr_cnt;
    n = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!rx_valid_o && n < 1200) begin
          cyc(1);
          n++;
        end
      end
    join
    in_win = (n >= 950 && n <= 958);
    check($sformatf("latency_window_n%0d", n), in_win, 1);
    check("latency_data", rx_data_o, 8'hA5);
    check("latency_ferr", ferr_cnt - base_f, 0);
    pop_all(1);

    // Short low glitch: rejected at the half-bit sample.
    base_f = ferr_cnt;
    base_o = ovr_cnt;
    busy_n = 0;
    for (int i = 0; i < 230; i++) begin
      rx_i = (i < 30) ? 1'b0 : 1'b1;
      cyc(1);
      if (busy_o) busy_n++;
    end
    in_win = (busy_n >= 48 && busy_n <= 52);
    check($sformatf("glitch_busy_len_%0d", busy_n), in_win, 1);
    check("glitch_valid", rx_valid_o, 0);
    check("glitch_ferr", ferr_cnt - base_f, 0);
    check("glitch_ovr", ovr_cnt - base_o, 0);

    // Bad stop followed by a long break: one error pulse, busy until release.
    base_f = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      d = 8'h3C;
      send_bit(d[i]);
    end
    rx_i = 1'b0;
    cyc(2000);
    check("break_busy_held", busy_o, 1);
    check("break_ferr_once", ferr_cnt - base_f, 1);
    check("break_no_push", rx_valid_o, 0);
    rx_i = 1'b1;
    cyc(10);
    check("break_busy_released", busy_o, 0);
    check("break_ferr_still_once", ferr_cnt - base_f, 1);

    // Five frames into a four-deep FIFO with the consumer stalled.
    base_o = ovr_cnt;
    for (int d = 1; d <= 5; d++) send_frame(8'(d), 1'b1);
    cyc(CPB);
    check("ovr_pulse", ovr_cnt - base_o, 1);
    check("ovr_valid", rx_valid_o, 1);
    check("ovr_head", rx_data_o, 8'h01);
    popped.delete();
    pop_all(10);
    check("ovr_popcnt", popped.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ovr_pop%0d", k), (k < popped.size()) ? popped[k] : 8'hEE, 8'(k + 1));
    end
    check("ovr_empty", rx_valid_o, 0);

    // Reset in the middle of bit 4 of 0xFF, then a clean 0x55.
    base_f = ferr_cnt;
    base_o = ovr_cnt;
    send_bit(1'b0);
    rx_i = 1'b1;
    cyc(4 * CPB + CPB / 2);
    rst_n = 1'b0;
    #2;
    check("midrst_busy_async", busy_o, 0);
    check("midrst_valid_async", rx_valid_o, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(5 * CPB);
    check("midrst_no_push", rx_valid_o, 0);
    popped.delete();
    send_frame(8'h55, 1'b1);
    cyc(CPB);
    check("midrst_valid", rx_valid_o, 1);
    check("midrst_data", rx_data_o, 8'h55);
    pop_all(3);
    check("midrst_popcnt", popped.size(), 1);
    check("midrst_ferr", ferr_cnt - base_f, 0);
    check("midrst_ovr", ovr_cnt - base_o, 0);

    // Back-to-back frames with the consumer always ready.
    base_f = ferr_cnt;
    base_o = ovr_cnt;
    popped.delete();
    rx_ready_i = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h80, 1'b1);
    cyc(CPB);
    rx_ready_i = 1'b0;
    cyc(1);
    check("b2b_popcnt", popped.size(), 3);
    check("b2b_pop0", (popped.size() > 0) ? popped[0] : 8'hEE, 8'h00);
    check("b2b_pop1", (popped.size() > 1) ? popped[1] : 8'hEE, 8'hFF);
    check("b2b_pop2", (popped.size() > 2) ? popped[2] : 8'hEE, 8'h80);
    check("b2b_ferr", ferr_cnt - base_f, 0);
    check("b2b_ovr", ovr_cnt - base_o, 0);
    check("b2b_empty", rx_valid_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning received-byte buffer entries (power of two, >= 2).
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rx_i  input  1  asynchronous serial line from the host UART; idles high.
REQ-006 rx_data_o  output  8  byte at FIFO head.
REQ-007 rx_valid_o  output  1  FIFO non-empty.
REQ-008 rx_ready_i  input  1  consumer accepts the head byte.
REQ-009 frame_err_o  output  1  one-cycle pulse on a bad stop bit.
REQ-010 overrun_o  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-011 busy_o  output  1  high in any FSM state other than IDLE.

Function
REQ-012 SHALL pass rx_i through a 2-flop synchronizer (both flops reset to 1); rx_s below denotes the synchronizer output.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: rx_s == 0 -> START, bit counter cleared; otherwise remain in IDLE.
REQ-015 START: sample rx_s when the counter reaches CLKS_PER_BIT/2-1 (216 at default, integer division).
- rx_s == 0 -> DATA, counter cleared.
- rx_s == 1 -> IDLE, glitch ignored, no flags raised.
REQ-016 DATA: sample rx_s every CLKS_PER_BIT cycles, LSB first, into an 8-bit shift register; after the 8th sample -> STOP.
REQ-017 STOP: sample rx_s CLKS_PER_BIT cycles after the 8th data sample.
- rx_s == 1 -> push the byte, go to IDLE.
- rx_s == 0 -> pulse frame_err_o, discard the byte, go to BREAK.
REQ-018 BREAK: remain until rx_s == 1, then go to IDLE; frame_err_o SHALL pulse only once per error.
REQ-019 Push SHALL occur on the cycle after the stop sample; rx_valid_o SHALL be high on the following cycle when the FIFO was empty.
REQ-020 Pop SHALL occur on every cycle with rx_valid_o && rx_ready_i; rx_data_o SHALL then present the next entry on the next cycle.
REQ-021 rx_data_o SHALL be stable while rx_valid_o is high and no pop occurs.
REQ-022 Push when full and no pop: byte dropped, overrun_o pulses, FIFO contents unchanged.
REQ-023 Push when full with a simultaneous pop: byte accepted, no overrun, occupancy unchanged.
REQ-024 Push when empty with no pop: occupancy becomes 1.
REQ-025 FIFO pointers SHALL be log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH, with an extra occupancy bit distinguishing full from empty.
REQ-026 The counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL not overflow.
REQ-027 The receiver SHALL detect a new start bit in IDLE on the first cycle rx_s is low, supporting back-to-back frames with a single stop bit.

Reset
REQ-028 While rst_n is low, regardless of clock:
- FSM = IDLE; counters, shift register and FIFO pointers cleared.
- rx_valid_o = 0, rx_data_o = 0x00, frame_err_o = 0, overrun_o = 0, busy_o = 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no push and no flag.
REQ-030 After deassertion the receiver SHALL wait for rx_s high-to-low before starting a frame; a line held low at release SHALL be treated as a start bit.
REQ-031 Reset deassertion SHALL be used only after external synchronization to clk.

Verification
REQ-032 Frame 0xA5 at 434 clk/bit, rx_ready_i = 0 -> rx_valid_o = 1 with rx_data_o = 0xA5 about 9.5 bit times plus 3 cycles after the start edge; no flags.
REQ-033 rx_i low for 100 cycles, then high -> FSM returns to IDLE; no push, no flags; busy_o high for about 217 cycles.
REQ-034 Frame 0x3C with stop bit 0, line held low 2000 cycles -> one frame_err_o pulse, no push, busy_o high until the line returns high.
REQ-035 Five frames 0x01..0x05, rx_ready_i = 0 throughout -> FIFO holds 0x01..0x04, one overrun_o pulse; then with rx_ready_i = 1, pops return 0x01..0x04 in order, then rx_valid_o = 0.
REQ-036 rst_n pulsed low during bit 4 of frame 0xFF, next frame 0x55 -> only 0x55 received.
REQ-037 Back-to-back frames 0x00, 0xFF, 0x80 with rx_ready_i = 1 -> all three popped in order, no flags.
